seg_value_display: RTL and testbench

Downstream consumer of the 2-bit digit-select count produced by the anode scan driver. Takes a binary amount (credit or price, in cents) from the vending controller, converts it to four BCD digits with a sequential double-dabble engine, holds the result in a display register, and drives the active-low 7-segment cathodes and decimal point for whichever digit the scan select currently addresses. The anode pattern and cathode pattern are aligned in the same cycle.

---
 rtl/display_pkg.sv | 39 +++
 rtl/seg_value_display_bin2bcd_seq.sv | 106 ++++++++++
 rtl/seg_value_display.sv | 91 +++++++++
 tb/tb_seg_value_display.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment value display:
// converter FSM states, active-low cathode patterns and the display limit.
package display_pkg;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    // Cathode order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    localparam int MAX_DISPLAY = 9999;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_value_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, with a single
// latest-wins pending slot so a value arriving mid-conversion is not lost.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int VAL_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] value,
    input  logic             value_valid,
    output logic [15:0]      bcd,
    output logic             overflow,
    output logic             load,
    output logic             valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(VAL_W);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(VAL_W - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic [VAL_W-1:0] pend_val;
    logic [VAL_W-1:0] shift_r;
    logic [15:0]      acc;
    logic             ovf_r;

    logic             start;
    logic [VAL_W-1:0] start_val;

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // A fresh value on the load cycle beats the stored pending one
    assign start     = ((state == IDLE) && value_valid) ||
                       ((state == LOAD) && (value_valid || pend));
    assign start_val = value_valid ? value : pend_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (value_valid) begin
                        state <= CONV;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CONV: begin
                    if (value_valid)
                        pend <= 1'b1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_SHIFT)
                        state <= LOAD;
                end
                LOAD: begin
                    valid <= 1'b1;
                    pend  <= 1'b0;
                    cnt   <= '0;
                    if (value_valid || pend) begin
                        state <= CONV;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; the FSM decides when they matter
    always_ff @(posedge clk) begin
        if (start) begin
            shift_r <= start_val;
            acc     <= '0;
            ovf_r   <= (int'(start_val) > MAX_DISPLAY);
        end else if (state == CONV) begin
            {acc, shift_r} <= {add3(acc), shift_r} << 1;
        end
        if (value_valid && (state != IDLE))
            pend_val <= value;
    end

    assign bcd      = acc;
    assign overflow = ovf_r;
    assign load     = (state == LOAD);

endmodule

// File: rtl/seg_value_display.sv
// Binary amount to four-digit seven-segment display, scanned by sel.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros left of the decimal point.
module seg_value_display
    import display_pkg::*;
#(
    parameter int DP_POS = 2,
    parameter int VAL_W  = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] value,
    input  logic             value_valid,
    input  logic [1:0]       sel,
    output logic [6:0]       seg,
    output logic             dp,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    logic [15:0] conv_bcd;
    logic        conv_ovf;
    logic        conv_load;

    logic [3:0]  disp [4];
    logic        ovf_r;
    logic [3:0]  digit;
    logic        blank;

    bin2bcd_seq #(
        .VAL_W(VAL_W)
    ) u_conv (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .value_valid(value_valid),
        .bcd        (conv_bcd),
        .overflow   (conv_ovf),
        .load       (conv_load),
        .valid      (done),
        .busy       (busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++)
                disp[i] <= 4'd0;
            ovf_r <= 1'b0;
        end else if (conv_load) begin
            for (int i = 0; i < 4; i++)
                disp[i] <= conv_bcd[4*i +: 4];
            ovf_r <= conv_ovf;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    localparam int BLANK_LIM = (DP_POS == 4) ? 0 : DP_POS;
    logic [3:0] zero_from;

    // zero_from[i]: digits i..3 are all zero
    always_comb begin
        zero_from = '0;
        for (int i = 0; i < 4; i++) begin
            zero_from[i] = 1'b1;
            for (int j = i; j < 4; j++) begin
                if (disp[j] != 4'd0)
                    zero_from[i] = 1'b0;
            end
        end
    end

    assign blank = (int'(sel) > BLANK_LIM) && zero_from[sel];
`else
    assign blank = 1'b0;
`endif

    assign digit = disp[sel];

    always_comb begin
        if (ovf_r)
            seg = DASH;
        else if (blank)
            seg = BLANK;
        else
            seg = seg_decode(digit);
        dp = ~((int'(sel) == DP_POS) && !ovf_r);
    end

    assign overflow = ovf_r;

endmodule

// File: tb/tb_seg_value_display.sv
// Scoreboard bench for seg_value_display: directed and random loads, pending
// overwrite, overflow dashes and mid-conversion reset against a decimal model.
module tb_seg_value_display;

    localparam int DP_POS = 2;
    localparam int VAL_W  = 14;
    localparam int LAT    = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [VAL_W-1:0] value = '0;
    logic             value_valid = 1'b0;
    logic [1:0]       sel = 2'd0;
    logic [6:0]       seg;
    logic             dp;
    logic             busy;
    logic             done;
    logic             overflow;

    seg_value_display #(
        .DP_POS(DP_POS),
        .VAL_W (VAL_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .value_valid(value_valid),
        .sel        (sel),
        .seg        (seg),
        .dp         (dp),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int v;
        int start;
        int done_e;
    } txn_t;

    txn_t q[$];
    int checks = 0;
    int failures = 0;
    int last_start = -100;
    int last_done = -100;
    int disp_val = 0;
    int sweep_req = 0;

    localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                        7'b0110000, 7'b0011001, 7'b0010010,
                                        7'b0000010, 7'b1111000, 7'b0000000,
                                        7'b0010000};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_seg(input int v, input int i);
        int p;
        int lim;
        logic [6:0] pat;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        lim = (DP_POS == 4) ? 0 : DP_POS;
        if (v > 9999) return 7'b0111111;
        pat = PAT[(v / p) % 10];
`ifdef LEADING_ZERO_BLANK_EN
        if (i > lim && v < p) pat = 7'b1111111;
`endif
        return int'(pat);
    endfunction

    task automatic sweep();
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            check($sformatf("seg_sel%0d_val%0d", i, disp_val), int'(seg), exp_seg(disp_val, i));
            check($sformatf("dp_sel%0d_val%0d", i, disp_val), int'(dp),
                  (i == DP_POS && disp_val <= 9999) ? 0 : 1);
        end
        check($sformatf("overflow_val%0d", disp_val), int'(overflow), (disp_val > 9999) ? 1 : 0);
    endtask

    // Monitor: pops expected results on done, checks busy every cycle
    initial begin
        int seen;
        int exp_busy;
        txn_t tx;
        seen = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        tx = q.pop_front();
                        check($sformatf("done_edge_val%0d", tx.v), cyc, tx.done_e);
                        disp_val = tx.v;
                        sweep();
                    end
                end else if (q.size() > 0 && cyc > q[0].done_e) begin
                    check($sformatf("done_timeout_val%0d", q[0].v), cyc, q[0].done_e);
                    void'(q.pop_front());
                end
                if (sweep_req != seen) begin
                    seen = sweep_req;
                    sweep();
                end
                exp_busy = (q.size() > 0 && q[0].start <= cyc) ? 1 : 0;
                check("busy", int'(busy), exp_busy);
            end
        end
    end

    // Called at posedge+1; the value is sampled by the next edge
    task automatic issue(input int v);
        int t;
        t = cyc + 1;
        if (q.size() > 0 && t <= last_start) begin
            q[q.size()-1].v = v;
        end else if (q.size() > 0 && t <= last_done) begin
            last_start = last_done;
            last_done  = last_done + LAT;
            q.push_back('{v: v, start: last_start, done_e: last_done});
        end else begin
            last_start = t;
            last_done  = t + LAT;
            q.push_back('{v: v, start: last_start, done_e: last_done});
        end
        value = VAL_W'(v);
        value_valid = 1'b1;
        @(posedge clk);
        #1;
        value_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() > 0) begin
            check("idle_timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int v;
        int r;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sweep_req++;
        repeat (2) @(posedge clk);
        #1;

        issue(1234);
        wait_idle();
        issue(10000);
        wait_idle();
        issue(5);
        wait_idle();
        issue(0);
        wait_idle();

        // 9999 arrives mid-conversion and is overwritten by 42
        issue(100);
        repeat (4) @(posedge clk);
        #1;
        issue(9999);
        repeat (2) @(posedge clk);
        #1;
        issue(42);
        wait_idle();

        // Reset during a conversion: no done, display back to zero
        issue(777);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        last_start = -100;
        last_done = -100;
        disp_val = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sweep_req++;
        repeat (25) @(posedge clk);
        #1;

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(0, 9999);
                2:       v = $urandom_range(10000, 16383);
                default: v = $urandom_range(0, 16383);
            endcase
            repeat ($urandom_range(0, 25)) @(posedge clk);
            #1;
            issue(v);
        end
        wait_idle();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
